fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
- Sequential IEEE-754 single-precision multiplier; the inverse operation of the FP ALU's combinational divider.
- Produces the same flag set (Overflow, Underflow, Exception) with the same saturation encodings.
- Uses a radix-2 shift-add mantissa datapath with valid/ready handshakes on both sides, so it drops into the ALU's pipelined operand path.

Parameters:
- BIAS, 127, exponent bias.
- MW, 24, mantissa width including the implied bit.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands n1/n2 are valid.
- in_ready  output  1  block is able to accept operands.
- n1  input  32  multiplicand, IEEE-754 single.
- n2  input  32  multiplier, IEEE-754 single.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  32  product.
- Overflow  output  1  exponent ≥255 after normalization; result = {sign, 8'hFF, 23'h0}.
- Underflow  output  1  exponent ≤0 after normalization; result = {sign, 31'h0}.
- Exception  output  1  either input exponent is all 1s; result = 32'hFFFFFFFF.

Behaviour:
Reset and handshake:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0. rst takes priority in any state and aborts any operation in progress; no output is produced for the aborted operation.
- Accept occurs when in_valid&&in_ready in IDLE. Operands are registered. in_ready=0 in every state except IDLE.

Arithmetic:
- sign = n1[31]^n2[31].
- Implied bit = |E; effective exponent Eeff = (E==0) ? 1 : E.
- Exponent is held as a signed 10-bit value: e = Eeff1 + Eeff2 − BIAS.

FSM:
- IDLE: on accept go to CLASSIFY.
- CLASSIFY (1 cycle):
  - Any exponent = 8'hFF: Exception=1, go to DONE.
  - Else either operand zero (E=0 and M=0): result = {sign, 31'h0}, no flags, go to DONE.
  - Else clear the 48-bit product P and go to MUL.
- MUL (exactly 24 cycles; 5-bit counter 0..23):
  - Each cycle, if the multiplier LSB is set, add the multiplicand to P.
  - Multiplicand shifts left, multiplier shifts right.
- NORM (one action per cycle):
  - If P[47]: mant = P[46:24], e += 1, go to PACK.
  - Else if P[46]: mant = P[45:23], go to PACK.
  - Else P <<= 1, e −= 1, stay in NORM. This path is reachable only for denormal inputs and is bounded at 46 cycles.
- PACK (1 cycle):
  - Priority: Exception > Underflow (e ≤ 0) > Overflow (e ≥ 255) > normal {sign, e[7:0], mant}.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags are held stable until out_ready.
  - On out_valid&&out_ready: out_valid=0, flags clear, go to IDLE (in_ready=1 the following cycle). No bypass from DONE to accept.

Latency and rounding:
- Latency for normal operands, accept to out_valid: 1 + 24 + 1 + 1 + 1 = 28 cycles. Special cases: 2 cycles.
- Default rounding is truncation, matching the divider.
- Only one flag may be high at a time.

Optional Feature:
- Macro: FP_MUL_ROUND_NEAREST_EN.
- Defined: PACK applies round-to-nearest-even.
  - Guard bit = the bit below the mantissa LSB; sticky = OR of all lower bits.
  - Increment when guard && (sticky || lsb).
  - Mantissa carry-out sets mant = 0 and e += 1, and this happens before the overflow check. PACK latency is unchanged.
- Undefined: truncation; guard and sticky logic is absent.

Decomposition:
- Shared package fp_pkg holds:
  - FP32 field widths and BIAS.
  - Constants FP_INF_MAG = 31'h7F800000 and FP_EXC = 32'hFFFFFFFF.
  - The state enum {IDLE, CLASSIFY, MUL, NORM, PACK, DONE}.
- One sub-module is natural: fp_mul_shift_add, the 24-cycle mantissa core with start/done.

Test Plan:
- 0x40000000 × 0x40400000 (2×3) → result 0x40C00000, flags 0, out_valid exactly 28 cycles after accept.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5) → 0x40100000, which exercises the P[47] normalization.
- 0x7F000000 × 0x40000000 → Overflow=1, 0x7F800000. 0x80800000 × 0x00800000 → Underflow=1, 0x80000000.
- 0x7F800000 × 0x3F800000 → Exception=1, 0xFFFFFFFF after 2 cycles. 0x00000000 × 0xC0000000 → 0x80000000, flags 0.
- 0x3F800001 × 0x3FC00000 → 0x3FC00001 without the macro; 0x3FC00002 with FP_MUL_ROUND_NEAREST_EN (tie, odd LSB).
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: result and flags are stable, in_ready=0.
  - Assert rst at MUL cycle 10: the next cycle shows IDLE, in_ready=1, out_valid=0, and there is no spurious output.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the sequential multiplier: field widths, bias,
// saturation encodings, FSM state codes and small field classifiers.
package fp_pkg;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;
  localparam int FP_MW     = 24;

  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;
  localparam logic [31:0] FP_EXC     = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLASSIFY = 3'd1,
    ST_MUL      = 3'd2,
    ST_NORM     = 3'd3,
    ST_PACK     = 3'd4,
    ST_DONE     = 3'd5
  } fp_state_e;

  function automatic logic is_special(input logic [31:0] x);
    return x[30:23] == 8'hFF;
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00) && (x[22:0] == 23'h0);
  endfunction
endpackage

// File: rtl/fp_mul_shift_add.sv
// Radix-2 shift-add mantissa core: start loads operands, MW add/shift steps,
// done marks the last step; shl shifts the idle product left for normalization.
module fp_mul_shift_add #(
  parameter int MW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            shl,
  input  logic [MW-1:0]   a,
  input  logic [MW-1:0]   b,
  output logic [2*MW-1:0] prod,
  output logic            done
);
  localparam logic [4:0] LAST = 5'(MW - 1);

  logic [2*MW-1:0] mcand;
  logic [MW-1:0]   mplier;
  logic [4:0]      cnt;
  logic            busy;

  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{MW{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + 5'd1;
    end else if (shl) begin
      prod <= prod << 1;
    end
  end
endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single multiplier: classify, 24-cycle shift-add, normalize, pack.
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even in PACK; default truncates.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int BIAS = FP_BIAS,
  parameter int MW   = FP_MW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] n1,
  input  logic [31:0] n2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Exception,
  output logic [2:0]  dbg_state
);
  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_CLASSIFY = ST_CLASSIFY;
  localparam logic [2:0] S_MUL      = ST_MUL;
  localparam logic [2:0] S_NORM     = ST_NORM;
  localparam logic [2:0] S_PACK     = ST_PACK;
  localparam logic [2:0] S_DONE     = ST_DONE;

  logic [2:0]        state;
  logic [31:0]       n1_q, n2_q;
  logic signed [9:0] e;
  logic [MW-2:0]     mant;
  logic [9:0]        eeff1, eeff2;
  logic              sign, special, zero, start, shl, done;
  logic [2*MW-1:0]   prod;
  logic signed [9:0] e_fin;
  logic [MW-2:0]     mant_fin;

  // Handshake: a transfer happens on a rising edge with valid && ready. in_ready is
  // high only in IDLE; out_valid only in DONE, which holds result/flags until taken.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  assign sign    = n1_q[31] ^ n2_q[31];
  assign special = is_special(n1_q) || is_special(n2_q);
  assign zero    = is_zero(n1_q) || is_zero(n2_q);
  assign eeff1   = (n1_q[30:23] == 8'h00) ? 10'd1 : {2'b00, n1_q[30:23]};
  assign eeff2   = (n2_q[30:23] == 8'h00) ? 10'd1 : {2'b00, n2_q[30:23]};
  assign start   = (state == S_CLASSIFY) && !special && !zero;
  assign shl     = (state == S_NORM) && !prod[2*MW-1] && !prod[2*MW-2];

  fp_mul_shift_add #(.MW(MW)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .shl   (shl),
    .a     ({|n1_q[30:23], n1_q[MW-2:0]}),
    .b     ({|n2_q[30:23], n2_q[MW-2:0]}),
    .prod  (prod),
    .done  (done)
  );

`ifdef FP_MUL_ROUND_NEAREST_EN
  logic guard, sticky;

  always_comb begin
    e_fin    = e;
    mant_fin = mant;
    if (guard && (sticky || mant[0])) begin
      // Mantissa carry-out renormalizes to 1.0 of the next binade.
      if (&mant) begin
        mant_fin = '0;
        e_fin    = e + 10'sd1;
      end else begin
        mant_fin = mant + {{(MW-2){1'b0}}, 1'b1};
      end
    end
  end
`else
  logic unused_prod_lo;
  assign unused_prod_lo = ^prod[MW-2:0];

  always_comb begin
    e_fin    = e;
    mant_fin = mant;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      n1_q      <= '0;
      n2_q      <= '0;
      e         <= '0;
      mant      <= '0;
      result    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Exception <= 1'b0;
`ifdef FP_MUL_ROUND_NEAREST_EN
      guard     <= 1'b0;
      sticky    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            n1_q  <= n1;
            n2_q  <= n2;
            state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          e <= $signed(eeff1 + eeff2 - 10'(BIAS));
          if (special) begin
            Exception <= 1'b1;
            result    <= FP_EXC;
            state     <= S_DONE;
          end else if (zero) begin
            result <= {sign, 31'h0};
            state  <= S_DONE;
          end else begin
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (done) state <= S_NORM;
        end
        S_NORM: begin
          if (prod[2*MW-1]) begin
            mant  <= prod[2*MW-2:MW];
            e     <= e + 10'sd1;
            state <= S_PACK;
`ifdef FP_MUL_ROUND_NEAREST_EN
            guard  <= prod[MW-1];
            sticky <= |prod[MW-2:0];
`endif
          end else if (prod[2*MW-2]) begin
            mant  <= prod[2*MW-3:MW-1];
            state <= S_PACK;
`ifdef FP_MUL_ROUND_NEAREST_EN
            guard  <= prod[MW-2];
            sticky <= |prod[MW-3:0];
`endif
          end else begin
            // Denormal operands only; the core shifts prod in step with this decrement.
            e <= e - 10'sd1;
          end
        end
        S_PACK: begin
          if (e_fin <= 10'sd0) begin
            Underflow <= 1'b1;
            result    <= {sign, 31'h0};
          end else if (e_fin >= 10'sd255) begin
            Overflow <= 1'b1;
            result   <= {sign, FP_INF_MAG};
          end else begin
            result <= {sign, e_fin[7:0], mant_fin};
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Exception <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: a real-arithmetic FP32 multiply model feeds an
// expected queue checked every DONE cycle; literal vectors pin the model itself.
module tb_fp_mul_seq;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] n1, n2, result;
  logic        Overflow, Underflow, Exception;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    int          hold;
  } vec_t;
  vec_t vecs[$];

  fp_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n1        (n1),
    .n2        (n2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Exception (Exception),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish by 400us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Flags are {Exception, Underflow, Overflow}; lat counts edges from accept to out_valid.
  function automatic void fp_model(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [2:0] f,
                                   output int lat);
    logic s;
    logic [7:0] ea, eb;
    longint unsigned ma, mb, p, frac, rem, half;
    int ex, shifts;
    s = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    r = '0;
    f = 3'b000;
    lat = 2;
    if (ea == 8'hFF || eb == 8'hFF) begin
      r = 32'hFFFFFFFF;
      f = 3'b100;
    end else if (a[30:0] == 31'h0 || b[30:0] == 31'h0) begin
      r = {s, 31'h0};
    end else begin
      ma = longint'(a[22:0]) + ((ea != 0) ? 64'h800000 : 64'h0);
      mb = longint'(b[22:0]) + ((eb != 0) ? 64'h800000 : 64'h0);
      ex = ((ea == 0) ? 1 : int'(ea)) + ((eb == 0) ? 1 : int'(eb)) - 127;
      p = ma * mb;
      shifts = 0;
      while (p < (64'd1 << 46)) begin
        p = p * 2;
        ex--;
        shifts++;
      end
      if (p >= (64'd1 << 47)) begin
        frac = (p >> 24) & 64'h7FFFFF;
        rem  = p & 64'hFFFFFF;
        half = 64'h800000;
        ex++;
      end else begin
        frac = (p >> 23) & 64'h7FFFFF;
        rem  = p & 64'h7FFFFF;
        half = 64'h400000;
      end
`ifdef FP_MUL_ROUND_NEAREST_EN
      if (rem > half || (rem == half && frac[0])) frac++;
      if (frac == 64'h800000) begin
        frac = 0;
        ex++;
      end
`else
      if (rem > half) frac = frac;
`endif
      lat = 28 + shifts;
      if (ex <= 0) begin
        r = {s, 31'h0};
        f = 3'b010;
      end else if (ex >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 3'b001;
      end else begin
        r = {s, ex[7:0], frac[22:0]};
      end
    end
  endfunction

  // scoreboard: compare on every cycle the result is presented
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("result", 64'(result), 64'(exp_q[0][31:0]));
        check("flags", 64'({Exception, Underflow, Overflow}), 64'(exp_q[0][34:32]));
        check("in_ready_in_done", 64'(in_ready), 64'd0);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                              input logic [2:0] f, input int lat, input int hold);
    vec_t v;
    v.a = a; v.b = b; v.r = r; v.f = f; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // driver: called at a negedge with the DUT idle
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input int idx);
    logic [31:0] r;
    logic [2:0]  f;
    int lat, n;
    fp_model(a, b, r, f, lat);
    exp_q.push_back({f, r});
    n1 = a;
    n2 = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_%0d", idx), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("latency_%0d", idx), 64'(n), 64'(lat));
    repeat (hold) begin
      @(negedge clk);
      check($sformatf("held_valid_%0d", idx), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("after_take_%0d", idx),
          64'({out_valid, Exception, Underflow, Overflow, in_ready}), 64'b00001);
  endtask

  initial begin
    logic [31:0] mr;
    logic [2:0]  mf;
    int mlat, cnt;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n1 = '0;
    n2 = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({dbg_state, in_ready, out_valid, Exception, Underflow, Overflow}),
          64'({3'(ST_IDLE), 5'b10000}));
    check("reset_result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back(mk(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 28, 0));
    vecs.push_back(mk(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 28, 0));
    vecs.push_back(mk(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b001, 28, 5));
    vecs.push_back(mk(32'h80800000, 32'h00800000, 32'h80000000, 3'b010, 28, 0));
    vecs.push_back(mk(32'h7F800000, 32'h3F800000, 32'hFFFFFFFF, 3'b100, 2, 5));
    vecs.push_back(mk(32'h00000000, 32'hC0000000, 32'h80000000, 3'b000, 2, 0));
`ifdef FP_MUL_ROUND_NEAREST_EN
    vecs.push_back(mk(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 28, 0));
`else
    vecs.push_back(mk(32'h3F800001, 32'h3FC00000, 32'h3FC00001, 3'b000, 28, 0));
`endif
    vecs.push_back(mk(32'h00400000, 32'h7E800000, 32'h3F000000, 3'b000, 29, 0));
    vecs.push_back(mk(32'hC0000000, 32'h3F000000, 32'hBF800000, 3'b000, 28, 0));
    vecs.push_back(mk(32'h3F800000, 32'hFF800000, 32'hFFFFFFFF, 3'b100, 2, 0));
    vecs.push_back(mk(32'h3F800000, 32'h80000000, 32'h80000000, 3'b000, 2, 0));
    vecs.push_back(mk(32'h00000001, 32'h4B000000, 32'h00800000, 3'b000, 51, 0));
    vecs.push_back(mk(32'h00000001, 32'h3F800000, 32'h00000000, 3'b010, 51, 0));
    vecs.push_back(mk(32'h00000001, 32'h00000001, 32'h00000000, 3'b010, 74, 0));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000, 28, 0));
    vecs.push_back(mk(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 28, 2));

    // pin the model against hand-computed products
    foreach (vecs[i]) begin
      fp_model(vecs[i].a, vecs[i].b, mr, mf, mlat);
      check($sformatf("model_%0d", i), 64'({mf, mr, 16'(mlat)}),
            64'({vecs[i].f, vecs[i].r, 16'(vecs[i].lat)}));
    end

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].hold, i);
    run_op(32'h40490FDB, 32'h40490FDB, 0, 100);
    run_op(32'hBF8CCCCD, 32'h42F60000, 1, 101);

    // abort an operation in the middle of the multiply
    n1 = 32'h40000000;
    n2 = 32'h40400000;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("rst_during_mul", 64'(dbg_state), 64'(3'(ST_MUL)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_state", 64'({dbg_state, in_ready, out_valid}), 64'({3'(ST_IDLE), 2'b10}));
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rst_no_output", 64'(cnt), 64'd0);

    run_op(32'h3FC00000, 32'h40000000, 0, 200);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
